// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - mdu_op_e      : operation encodings presented on the op port
//   - mdu_state_e   : controller FSM states
//   - ITER_DEFAULT  : default number of radix-2 iterations per operation
//   - DIV0_LO       : LO value written on a divide by zero
//   - mdu_abs       : magnitude helper used when launching signed operations
// ---------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_e;

   localparam int ITER_DEFAULT = 32;

   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   // Magnitude of a 32-bit operand. INT_MIN maps onto 0x80000000, which is
   // still the correct magnitude when read as an unsigned number.
   function automatic logic [31:0] mdu_abs(input logic [31:0] value, input logic is_signed);
      logic [31:0] result;
      result = value;
      if (is_signed && value[31]) begin
         result = -value;
      end
      return result;
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// ---------------------------------------------------------------------------
// mdu_iter_core
// Purely combinational single-step datapath for the multiply/divide unit.
// One call of this block advances the {acc_hi, acc_lo} accumulator by one
// radix-2 iteration.
//   is_div   in   1   1 = restoring divide step, 0 = shift/add multiply step
//   acc_hi   in  32   upper accumulator (partial product / partial remainder)
//   acc_lo   in  32   lower accumulator (multiplier bits / dividend->quotient)
//   operand  in  32   multiplicand magnitude or divisor magnitude
//   next_hi  out 32   accumulator upper half after this iteration
//   next_lo  out 32   accumulator lower half after this iteration
// ---------------------------------------------------------------------------
module mdu_iter_core (
   input  logic        is_div,
   input  logic [31:0] acc_hi,
   input  logic [31:0] acc_lo,
   input  logic [31:0] operand,
   output logic [31:0] next_hi,
   output logic [31:0] next_lo
);

   logic [32:0] sum;
   logic [32:0] shifted;
   logic        fits;

   // Multiply: conditionally add the multiplicand into the upper half, then
   // shift the 65-bit {carry, hi, lo} right by one so the carry is kept.
   // Divide: shift the next dividend bit into the partial remainder and
   // subtract the divisor when it fits. The true difference is always below
   // 2^32 when it fits, so a 32-bit wrapped subtract gives the exact value.
   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
      shifted = {acc_hi, acc_lo[31]};
      fits    = (shifted >= {1'b0, operand});
      next_hi = sum[32:1];
      next_lo = {sum[0], acc_lo[31:1]};
      if (is_div) begin
         if (fits) begin
            next_hi = shifted[31:0] - operand;
            next_lo = {acc_lo[30:0], 1'b1};
         end else begin
            next_hi = shifted[31:0];
            next_lo = {acc_lo[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operations run on operand magnitudes; signs are applied in the final FIX
// cycle so the iterative core only ever sees unsigned arithmetic.
//   clk       in   1   clock, rising edge
//   rstn      in   1   asynchronous active-low reset
//   start     in   1   launch op with operands a, b (ignored while busy)
//   op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a         in  32   multiplicand / dividend
//   b         in  32   multiplier / divisor
//   mthi      in   1   write wdata into hi (idle only, start wins)
//   mtlo      in   1   write wdata into lo (idle only, start wins)
//   wdata     in  32   data for mthi/mtlo
//   hilo_use  in   1   current instruction needs hi/lo or the unit
//   hi, lo    out 32   architectural HI/LO
//   busy      out  1   operation in progress
//   stall     out  1   busy & hilo_use
// ---------------------------------------------------------------------------
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int ITER = ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        hilo_use,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall
);

   localparam int CNT_W = $clog2(ITER + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

   mdu_state_e       state;
   mdu_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      operand_q;
   logic [31:0]      acc_hi;
   logic [31:0]      acc_lo;
   logic             neg_lo;
   logic             neg_hi;
   logic             div0;

   logic             op_signed;
   logic             op_is_div;
   logic [31:0]      mag_a;
   logic [31:0]      mag_b;
   logic [31:0]      step_hi;
   logic [31:0]      step_lo;
   logic [63:0]      product;
   logic [31:0]      fix_hi;
   logic [31:0]      fix_lo;

   // Launch-time decode of the incoming operation and operand magnitudes.
   // MULT and DIV are the signed forms, i.e. op[0] low.
   always_comb begin
      op_signed = ~op[0];
      op_is_div = op[1];
      mag_a     = mdu_abs(a, op_signed);
      mag_b     = mdu_abs(b, op_signed);
   end

   mdu_iter_core u_core (
      .is_div  (op_q[1]),
      .acc_hi  (acc_hi),
      .acc_lo  (acc_lo),
      .operand (operand_q),
      .next_hi (step_hi),
      .next_lo (step_lo)
   );

   // Sign correction of the finished magnitude result. A divide by zero
   // already leaves the dividend magnitude in acc_hi, so the remainder sign
   // rule reproduces a exactly; only LO needs overriding.
   always_comb begin
      product = {acc_hi, acc_lo};
      if (neg_lo) begin
         product = -{acc_hi, acc_lo};
      end
      if (op_q[1]) begin
         fix_hi = neg_hi ? -acc_hi : acc_hi;
         fix_lo = neg_lo ? -acc_lo : acc_lo;
         if (div0) begin
            fix_lo = DIV0_LO;
         end
      end else begin
         fix_hi = product[63:32];
         fix_lo = product[31:0];
      end
   end

   // Controller FSM. IDLE latches a new operation (start beats any move),
   // CALC runs ITER core iterations, FIX commits the signed result to HI/LO.
   // HI/LO change only through moves in IDLE or the FIX commit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         op_q      <= OP_MULT;
         cnt       <= '0;
         operand_q <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         neg_lo    <= 1'b0;
         neg_hi    <= 1'b0;
         div0      <= 1'b0;
         busy      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_CALC;
                  op_q   <= mdu_op_e'(op);
                  cnt    <= '0;
                  busy   <= 1'b1;
                  acc_hi <= '0;
                  div0   <= op_is_div && (b == 32'd0);
                  neg_lo <= op_signed && (a[31] ^ b[31]);
                  neg_hi <= op_signed && op_is_div && a[31];
                  if (op_is_div) begin
                     operand_q <= mag_b;
                     acc_lo    <= mag_a;
                  end else begin
                     operand_q <= mag_a;
                     acc_lo    <= mag_b;
                  end
               end else begin
                  if (mthi) begin
                     hi <= wdata;
                  end
                  if (mtlo) begin
                     lo <= wdata;
                  end
               end
            end
            ST_CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign stall = busy & hilo_use;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
// Directed self-checking bench for mdu_ctrl. Inputs change and outputs are
// sampled on the falling clock edge (or 1 time unit after a rising edge),
// well away from the active edge. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

   localparam int ITER = 32;
   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        hilo_use;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall;

   int checks = 0;
   int errors = 0;
   int done_c;

   mdu_ctrl #(.ITER(ITER)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .wdata    (wdata),
      .hilo_use (hilo_use),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .stall    (stall)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and on mismatch counts the failure and
   // reports the tag with observed and expected values.
   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Presents one start (optionally with a simultaneous mthi) for one rising
   // edge, then returns on the falling edge right after that launch edge.
   task automatic apply_stimulus(input logic [1:0] op_v, input logic [31:0] a_v,
                                 input logic [31:0] b_v, input logic with_mthi);
      @(negedge clk);
      start = 1'b1;
      op    = op_v;
      a     = a_v;
      b     = b_v;
      mthi  = with_mthi;
      wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
   endtask

   // Counts rising edges after the launch edge until busy drops, bounded so
   // the bench cannot hang; the count must equal ITER+1.
   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      check_output({tag, "_busy_rise"}, busy, 1);
      while (cyc < 3 * ITER) begin
         @(posedge clk);
         #1;
         cyc++;
         if (!busy) break;
      end
      check_output({tag, "_latency"}, cyc, ITER + 1);
   endtask

   task automatic run_op(input string tag, input logic [1:0] op_v, input logic [31:0] a_v,
                         input logic [31:0] b_v, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      apply_stimulus(op_v, a_v, b_v, 1'b0);
      wait_done(tag);
      check_output({tag, "_hi"}, hi, exp_hi);
      check_output({tag, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      rstn     = 1'b1;
      start    = 1'b0;
      op       = MULT;
      a        = '0;
      b        = '0;
      mthi     = 1'b0;
      mtlo     = 1'b0;
      wdata    = '0;
      hilo_use = 1'b1;

      // Reset values, with hilo_use high so a stuck stall shows up.
      #2 rstn = 1'b0;
      #1;
      check_output("rst_hi", hi, 32'h0);
      check_output("rst_lo", lo, 32'h0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_stall", stall, 1'b0);
      repeat (2) @(negedge clk);
      rstn     = 1'b1;
      hilo_use = 1'b0;

      // Basic multiplies and divides, including sign and carry corners.
      run_op("multu_7x6", MULTU, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A);
      run_op("mult_m3x5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_intmin", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
      run_op("divu_by0", DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF);
      run_op("div_m7by0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // Moves in IDLE: single and simultaneous.
      @(negedge clk);
      mthi  = 1'b1;
      wdata = 32'h1234_5678;
      @(negedge clk);
      mthi  = 1'b0;
      check_output("mthi_hi", hi, 32'h1234_5678);
      check_output("mthi_lo_kept", lo, 32'hFFFF_FFFF);
      mtlo  = 1'b1;
      wdata = 32'h9ABC_DEF0;
      @(negedge clk);
      mtlo  = 1'b0;
      check_output("mtlo_lo", lo, 32'h9ABC_DEF0);
      check_output("mtlo_hi_kept", hi, 32'h1234_5678);
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h55AA_55AA;
      @(negedge clk);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      check_output("mtboth_hi", hi, 32'h55AA_55AA);
      check_output("mtboth_lo", lo, 32'h55AA_55AA);

      // Start together with mthi: the move is dropped, HI/LO untouched
      // until the result lands.
      apply_stimulus(MULTU, 32'd2, 32'd3, 1'b1);
      check_output("prio_hi_held", hi, 32'h55AA_55AA);
      check_output("prio_lo_held", lo, 32'h55AA_55AA);
      wait_done("prio");
      check_output("prio_hi", hi, 32'h0);
      check_output("prio_lo", lo, 32'h6);

      // Stall while busy, ignored mthi and start, operand changes after launch.
      apply_stimulus(MULTU, 32'd9, 32'd9, 1'b0);
      done_c = 0;
      for (int c = 1; c <= 3 * ITER; c++) begin
         @(negedge clk);
         if (c == 5) hilo_use = 1'b1;
         if (c == 8) begin
            mthi  = 1'b1;
            wdata = 32'hCAFE_F00D;
            a     = 32'd100;
            b     = 32'd100;
         end
         if (c == 9) begin
            mthi  = 1'b0;
            start = 1'b1;
            op    = DIVU;
         end
         if (c == 10) start = 1'b0;
         #1;
         if (!busy) begin
            done_c = c;
            break;
         end
         if (c == 4) check_output("stall_before_use", stall, 1'b0);
         if (c == 5) check_output("stall_c5", stall, 1'b1);
         if (c == 9) check_output("busy_mthi_ignored", hi, 32'h0);
         if (c == 20) check_output("stall_c20", stall, 1'b1);
         if (c == ITER) check_output("stall_last", stall, 1'b1);
      end
      check_output("stall_latency", done_c, ITER + 1);
      check_output("stall_released", stall, 1'b0);
      check_output("stall_op_hi", hi, 32'h0);
      check_output("stall_op_lo", lo, 32'h51);
      hilo_use = 1'b0;
      @(negedge clk);
      check_output("busy_start_ignored", busy, 1'b0);

      // Reset in the middle of a DIVU aborts it; then a fresh MULTU.
      @(negedge clk);
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h1111_1111;
      @(negedge clk);
      mthi  = 1'b0;
      mtlo  = 1'b0;
      apply_stimulus(DIVU, 32'd1000, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      check_output("pre_rst_hi_held", hi, 32'h1111_1111);
      rstn = 1'b0;
      #1;
      check_output("midrst_hi", hi, 32'h0);
      check_output("midrst_lo", lo, 32'h0);
      check_output("midrst_busy", busy, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      run_op("post_rst_multu", MULTU, 32'd2, 32'd3, 32'h0, 32'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter ITER, default 32, number of shift/add or shift/subtract iterations per operation.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  launch a multiply/divide using op, a, b.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand (multiplicand or dividend).
REQ-007 b  input  32  rt operand (multiplier or divisor).
REQ-008 mthi, mtlo  input  1 each  write wdata to hi or lo.
REQ-009 wdata  input  32  data for mthi/mtlo.
REQ-010 hilo_use  input  1  current instruction reads hi/lo or issues start.
REQ-011 hi, lo  output  32 each  architectural HI/LO registers.
REQ-012 busy  output  1  operation in progress.
REQ-013 stall  output  1  CPU must hold PC and instruction; stall = busy & hilo_use (combinational).

Function
REQ-014 FSM states: IDLE, CALC, FIX; encoding defined in mdu_pkg.
REQ-015 IDLE with start=1: latch op, operand magnitudes (abs for signed ops), result signs, and clear the iteration counter; go to CALC; busy=1 from that edge.
REQ-016 CALC: one radix-2 iteration per cycle; after ITER iterations go to FIX.
REQ-017 FIX: apply sign correction, write hi/lo, return to IDLE; busy=0 from that edge.
REQ-018 Latency: start sampled at edge k; hi/lo hold the result and busy=0 after edge k+ITER+1 (k+33 at the default); busy is high for ITER+1 cycles.
REQ-019 Multiply: {hi,lo} = full 64-bit product; signed if MULT.
REQ-020 Divide: lo = quotient, hi = remainder.
REQ-021 Divide sign rules: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-022 Signed INT_MIN / -1 gives lo=0x80000000, hi=0.
REQ-023 Divide by zero (DIV or DIVU) gives hi=a, lo=0xFFFFFFFF, with full latency.
REQ-024 start, mthi and mtlo are ignored while busy=1; hi/lo are not modified until FIX.
REQ-025 In IDLE, start has priority over mthi/mtlo in the same cycle; the move is dropped.
REQ-026 In IDLE with mthi and mtlo both asserted, both registers load wdata.
REQ-027 Operands are captured at launch; later changes to a/b have no effect.

Reset
REQ-028 rstn low, asynchronous: state=IDLE, hi=0, lo=0, busy=0, counter=0, internal operand and accumulator registers=0.
REQ-029 Reset mid-operation aborts the operation with no partial write to hi/lo; the first start after rstn rises behaves per REQ-015.

Structure
REQ-030 mdu_pkg holds: op encodings, FSM state type, the ITER default, and the divide-by-zero LO constant 0xFFFFFFFF.
REQ-031 One sub-module, mdu_iter_core, holds the per-iteration shift/add/subtract datapath; mdu_ctrl holds the FSM, counter, sign handling and HI/LO.

Verification
REQ-032 MULTU a=7, b=6 -> after 33 cycles hi=0x00000000, lo=0x0000002A, busy falls.
REQ-033 MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF after full latency.
REQ-036 Stall and ignore: start, then hilo_use=1 at cycle 5 -> stall=1 until busy falls; a mthi issued during busy leaves hi unchanged.
REQ-037 rstn pulsed low at cycle 10 of a DIVU -> hi=lo=0 and busy=0 immediately; a new MULTU 2x3 then yields lo=6.
